// File: rtl/rr_onehot_arb_mux.sv
// rr_onehot_arb_mux
//   Registered N-to-1 round-robin channel selector. A one-hot grant drives an
//   AND-OR data mux into a single-entry output register. Optional packet lock
//   keeps the grant on one channel until its last beat is accepted.
//
// Ports
//   Clk, RstN  : clock (rising edge) / asynchronous active-low reset
//   InValid    : per-channel valid
//   InReady    : per-channel ready, at most one bit high
//   InData     : per-channel data, channel i in slice [i*DATA_W +: DATA_W]
//   InLast     : per-channel last-beat flag
//   OutValid   : output register holds a beat
//   OutReady   : sink accepts the held beat
//   OutData    : registered muxed data
//   OutLast    : registered last flag of the held beat
//   OutGrant   : registered one-hot source of the held beat
module rr_onehot_arb_mux #(
  parameter int DATA_W       = 32,
  parameter int SEL_NUM      = 4,
  parameter int LOCK_ON_LAST = 1
) (
  input  logic                      Clk,
  input  logic                      RstN,
  input  logic [SEL_NUM-1:0]        InValid,
  output logic [SEL_NUM-1:0]        InReady,
  input  logic [SEL_NUM*DATA_W-1:0] InData,
  input  logic [SEL_NUM-1:0]        InLast,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [DATA_W-1:0]         OutData,
  output logic                      OutLast,
  output logic [SEL_NUM-1:0]        OutGrant
);

  localparam int IDX_W = (SEL_NUM > 1) ? $clog2(SEL_NUM) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   lock_idx;
  logic               locked;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic [SEL_NUM-1:0] grant;
  logic [DATA_W-1:0]  mux_data;
  logic               sel_last;
  logic               load_en;
  logic               accept;

  // (base + k) mod SEL_NUM, valid for any SEL_NUM, not just powers of two
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= SEL_NUM) s = s - SEL_NUM;
    return IDX_W'(s);
  endfunction

  // While locked, only the lock owner can be granted, even when it is idle.
  always_comb begin
    grant   = '0;
    sel_idx = ptr;
    cand    = ptr;
    found   = 1'b0;
    if (locked) begin
      sel_idx         = lock_idx;
      grant[lock_idx] = InValid[lock_idx];
    end else begin
      for (int k = 0; k < SEL_NUM; k++) begin
        cand = wrap_add(ptr, k);
        if (!found && InValid[cand]) begin
          found       = 1'b1;
          sel_idx     = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mux_data = '0;
    for (int j = 0; j < SEL_NUM; j++) begin
      mux_data = mux_data | ({DATA_W{grant[j]}} & InData[j*DATA_W +: DATA_W]);
    end
  end

  assign sel_last = |(grant & InLast);
  assign load_en  = !OutValid || OutReady;
  // Gated by RstN so no channel sees ready while reset is held.
  assign InReady  = RstN ? (grant & {SEL_NUM{load_en}}) : '0;
  assign accept   = |InReady;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      OutValid <= 1'b0;
      OutData  <= '0;
      OutLast  <= 1'b0;
      OutGrant <= '0;
      ptr      <= '0;
      lock_idx <= '0;
      locked   <= 1'b0;
    end else if (accept) begin
      OutValid <= 1'b1;
      OutData  <= mux_data;
      OutLast  <= sel_last;
      OutGrant <= grant;
      // Pointer only moves once the channel gives up the grant.
      if ((LOCK_ON_LAST != 0) && !sel_last) begin
        locked   <= 1'b1;
        lock_idx <= sel_idx;
      end else begin
        locked <= 1'b0;
        ptr    <= wrap_add(sel_idx, 1);
      end
    end else if (load_en) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_onehot_arb_mux.sv
module tb_rr_onehot_arb_mux;

  localparam int DW = 32;
  localparam int SN = 4;

  logic            Clk;
  logic            RstN;
  logic [SN-1:0]   InValid;
  logic [SN-1:0]   InReady;
  logic [SN*DW-1:0] InData;
  logic [SN-1:0]   InLast;
  logic            OutValid;
  logic            OutReady;
  logic [DW-1:0]   OutData;
  logic            OutLast;
  logic [SN-1:0]   OutGrant;

  typedef struct packed {
    logic [SN-1:0] grant;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  rr_onehot_arb_mux #(.DATA_W(DW), .SEL_NUM(SN), .LOCK_ON_LAST(1)) dut (
    .Clk(Clk), .RstN(RstN),
    .InValid(InValid), .InReady(InReady), .InData(InData), .InLast(InLast),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutLast(OutLast), .OutGrant(OutGrant)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [SN-1:0] g, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.grant = g;
    b.data  = d;
    b.last  = l;
    exp_q.push_back(b);
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] d);
    InData[ch*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every beat retired at the output is compared with the scoreboard head.
  always @(negedge Clk) begin
    if (RstN && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_grant", {60'd0, OutGrant}, 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_grant", {60'd0, OutGrant}, {60'd0, e.grant});
        check("beat_data",  {32'd0, OutData},  {32'd0, e.data});
        check("beat_last",  {63'd0, OutLast},  {63'd0, e.last});
      end
    end
  end

  initial begin
    RstN     = 1'b0;
    InValid  = 4'b1111;
    InLast   = 4'b1111;
    OutReady = 1'b1;
    for (int i = 0; i < SN; i++) set_data(i, 32'hD000_0000 + i);

    // Reset holds all channels off even with every channel valid.
    repeat (2) step();
    check("rst_inready",  {60'd0, InReady},  64'd0);
    check("rst_outvalid", {63'd0, OutValid}, 64'd0);
    check("rst_outgrant", {60'd0, OutGrant}, 64'd0);

    // Round robin from channel 0, one beat per cycle.
    push(4'b0001, 32'hD000_0000, 1'b1);
    push(4'b0010, 32'hD000_0001, 1'b1);
    push(4'b0100, 32'hD000_0002, 1'b1);
    push(4'b1000, 32'hD000_0003, 1'b1);
    push(4'b0001, 32'hD000_0000, 1'b1);
    RstN = 1'b1;
    repeat (5) step();
    InValid = 4'b0000;
    repeat (2) step();

    // Sparse requesters 1 and 3, pointer starts at 1.
    push(4'b0010, 32'hD000_0001, 1'b1);
    push(4'b1000, 32'hD000_0003, 1'b1);
    push(4'b0010, 32'hD000_0001, 1'b1);
    push(4'b1000, 32'hD000_0003, 1'b1);
    InValid = 4'b1010;
    repeat (4) step();
    InValid = 4'b0000;
    repeat (2) step();

    // Backpressure on a ch2 beat, then retire and load in the same cycle.
    set_data(2, 32'hA5A5_A5A5);
    push(4'b0100, 32'hA5A5_A5A5, 1'b1);
    push(4'b0100, 32'h5A5A_5A5A, 1'b1);
    InValid = 4'b0100;
    step();
    OutReady = 1'b0;
    set_data(2, 32'h5A5A_5A5A);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("bp_outvalid", {63'd0, OutValid}, 64'd1);
      check("bp_outdata",  {32'd0, OutData},  64'hA5A5_A5A5);
      check("bp_inready",  {60'd0, InReady},  64'd0);
      @(posedge Clk);
      #1;
    end
    OutReady = 1'b1;
    step();
    InValid = 4'b0000;
    repeat (2) step();

    // Idle bubble: one ch0 beat (pointer at 3 -> wraps to 0).
    set_data(0, 32'hB0B0_0000);
    push(4'b0001, 32'hB0B0_0000, 1'b1);
    InValid = 4'b0001;
    step();
    InValid = 4'b0000;
    @(negedge Clk);
    check("bubble_valid_hi", {63'd0, OutValid}, 64'd1);
    @(negedge Clk);
    check("bubble_valid_lo", {63'd0, OutValid}, 64'd0);
    @(negedge Clk);
    check("bubble_valid_lo2", {63'd0, OutValid}, 64'd0);
    @(posedge Clk);
    #1;

    // Packet lock: ch1 3-beat packet while ch0 and ch3 stay valid.
    set_data(0, 32'hD000_0000);
    set_data(1, 32'h1111_0001);
    push(4'b0010, 32'h1111_0001, 1'b0);
    push(4'b0010, 32'h1111_0002, 1'b0);
    push(4'b0010, 32'h1111_0003, 1'b1);
    push(4'b1000, 32'hD000_0003, 1'b1);
    push(4'b0001, 32'hD000_0000, 1'b1);
    InLast  = 4'b1101;
    InValid = 4'b1011;
    step();
    InValid = 4'b1001;
    @(negedge Clk);
    check("lock_hold1", {60'd0, InReady}, 64'd0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check("lock_hold2", {60'd0, InReady}, 64'd0);
    @(posedge Clk);
    #1;
    InValid = 4'b1011;
    set_data(1, 32'h1111_0002);
    @(negedge Clk);
    check("lock_resume", {60'd0, InReady}, 64'b0010);
    @(posedge Clk);
    #1;
    set_data(1, 32'h1111_0003);
    InLast = 4'b1111;
    @(negedge Clk);
    check("lock_last_ready", {60'd0, InReady}, 64'b0010);
    @(posedge Clk);
    #1;
    InValid = 4'b1001;
    repeat (2) step();
    InValid = 4'b0000;
    repeat (2) step();

    // Async reset while locked on ch2 with a held beat.
    set_data(2, 32'hC2C2_0001);
    InLast  = 4'b1011;
    InValid = 4'b0100;
    step();
    OutReady = 1'b0;
    check("prerst_outvalid", {63'd0, OutValid}, 64'd1);
    check("prerst_outgrant", {60'd0, OutGrant}, 64'b0100);
    #1;
    RstN = 1'b0;
    #1;
    check("arst_outvalid", {63'd0, OutValid}, 64'd0);
    check("arst_outgrant", {60'd0, OutGrant}, 64'd0);
    check("arst_inready",  {60'd0, InReady},  64'd0);
    @(posedge Clk);
    #1;
    RstN     = 1'b1;
    InLast   = 4'b1111;
    OutReady = 1'b1;
    set_data(2, 32'hE2E2_0002);
    push(4'b0001, 32'hD000_0000, 1'b1);
    push(4'b0100, 32'hE2E2_0002, 1'b1);
    InValid = 4'b0101;
    repeat (2) step();
    InValid = 4'b0000;
    repeat (3) step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arb_mux.md
Name: rr_onehot_arb_mux

Overview:
- Registered N-to-1 channel selector: round-robin arbitration across SEL_NUM valid/ready input channels.
- Grant is one-hot; it drives an AND-OR one-hot data mux into a single-entry output register.
- Optional packet lock holds the grant across multi-beat transfers until the Last beat.
- Sits in front of shared sinks (bus masters, shared FIFOs) that need fair multi-source access.

Parameters:
- DATA_W, 32, width of each channel's data word.
- SEL_NUM, 4, number of input channels (>=2).
- LOCK_ON_LAST, 1, 1 = hold grant on a channel until its beat with InLast=1 is accepted; 0 = re-arbitrate every beat.

Ports:
- Clk  input  1  clock, all state on rising edge.
- RstN  input  1  asynchronous active-low reset.
- InValid  input  SEL_NUM  per-channel valid.
- InReady  output  SEL_NUM  per-channel ready, at most one bit high.
- InData  input  SEL_NUM x DATA_W  per-channel data, channel i in slice i.
- InLast  input  SEL_NUM  per-channel last-beat flag.
- OutValid  output  1  output register holds a beat.
- OutReady  input  1  sink accepts the beat.
- OutData  output  DATA_W  registered muxed data.
- OutLast  output  1  registered last flag of the held beat.
- OutGrant  output  SEL_NUM  registered one-hot source of the held beat.

Behaviour:
- Reset (RstN=0, asynchronous): OutValid=0, OutData=0, OutLast=0, OutGrant=0, priority pointer = channel 0, lock cleared. InReady=0 while RstN=0.
- Load enable: LoadEn = !OutValid | OutReady. Full throughput: one beat per cycle when the sink is always ready.
- Arbitration is combinational each cycle.
  - Unlocked: Grant = first channel with InValid=1, searching cyclically upward from the pointer.
  - Locked: Grant = lock channel when its InValid=1, else 0.
  - InReady = Grant & {SEL_NUM{LoadEn}}.
  - InReady[i] does not depend on InValid[j] for j!=i except through arbitration. InReady does not depend combinationally on OutValid/OutReady beyond LoadEn.
- Accept: a beat on channel i is accepted when InValid[i] & InReady[i].
- On accept:
  - OutData <= InData[i], built as OR over j of ({DATA_W{Grant[j]}} & InData[j]).
  - OutLast <= InLast[i].
  - OutGrant <= Grant.
  - OutValid <= 1.
- If LoadEn=1 and no accept: OutValid <= 0. OutData, OutLast and OutGrant hold their last values; they are don't-care when OutValid=0.
- If LoadEn=0, all output registers hold (backpressure). Data is stable while OutValid & !OutReady.
- Pointer update, on accept only:
  - pointer <= (i+1) mod SEL_NUM, including wrap from SEL_NUM-1 to 0.
  - When the accept sets or keeps the lock, the pointer is unchanged.
- Lock, only when LOCK_ON_LAST=1:
  - Accept with InLast=0 sets lock on channel i.
  - Accept from the locked channel with InLast=1 clears the lock and advances the pointer to (i+1) mod SEL_NUM.
  - While locked, other channels get InReady=0 even if the locked channel is idle.
  - With LOCK_ON_LAST=0, InLast only passes through to OutLast.
- Simultaneous events:
  - OutReady=1 with a new accept in the same cycle: the old beat retires and the new beat loads. No bubble, no duplication.
  - Multiple InValid: exactly one grant, chosen by the pointer order.
- Protocol: an input that drops InValid before acceptance is legal and is simply not granted. Outputs obey valid/ready: OutValid is never deasserted while OutReady=0.
- Reset mid-packet: lock, pointer and output register return to reset values immediately. A partially transferred packet is discarded; no recovery beat is generated.

Test Plan:
- Reset: RstN=0 with InValid=4'b1111 -> InReady=0, OutValid=0, OutGrant=0. Release, OutReady=1 -> first beat from ch0, then ch1, ch2, ch3, ch0, one beat per cycle.
- Fairness with a sparse requester: InValid=4'b1010 constant, OutReady=1, LOCK_ON_LAST=0 -> OutGrant sequence 0010, 1000, 0010, 1000. Pointer wraps from 3 to 0 correctly.
- Backpressure: ch2 sends 0xA5A5A5A5, OutReady=0 for 3 cycles -> OutData/OutValid stable; InReady=0 for those 3 cycles. OutReady=1 -> retire and accept the next beat in the same cycle.
- Packet lock (LOCK_ON_LAST=1): ch1 sends a 3-beat packet (Last on beat 3) while ch0 and ch3 are valid throughout; ch1 InValid drops for 2 cycles mid-packet -> ch0/ch3 InReady stay 0 until ch1's Last beat. Next grant goes to ch3 (pointer 2 -> first valid = ch3).
- Idle bubble: single beat on ch0, then all InValid=0 with OutReady=1 -> OutValid=1 for exactly one cycle, then 0. OutData holds 0-or-last value, not checked.
- Async reset mid-packet: assert RstN=0 between edges while locked on ch2 with OutValid=1 -> OutValid=0 immediately, not at the next edge. After release, ch0 is granted first with no lock.
